// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider: FSM state encoding,
// operand widths and the saturated quotient value returned on the
// divide-by-zero and overflow paths.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_DW = 16;    // dividend width
    localparam int DIV_QW = 8;     // divisor / quotient / remainder width

    localparam logic [DIV_QW-1:0] DIV_QSAT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   i_rem      : current partial remainder R (always < i_divisor)
//   i_divisor  : divisor
//   i_bit      : next dividend bit, MSB first
//   o_rem      : partial remainder after this step
//   o_qbit     : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
(
    input  logic [DIV_QW-1:0] i_rem,
    input  logic [DIV_QW-1:0] i_divisor,
    input  logic              i_bit,
    output logic [DIV_QW-1:0] o_rem,
    output logic              o_qbit
);

    logic [DIV_QW:0]   w_shift;   // {R, bit}; 9 bits suffice because R < divisor
    logic [DIV_QW+1:0] w_diff;    // signed-width trial subtraction

    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
        // A clear sign bit means the subtraction fits; the difference is then
        // below the divisor, so its low 8 bits hold the whole value.
        if (!w_diff[DIV_QW+1]) begin
            o_rem  = w_diff[DIV_QW-1:0];
            o_qbit = 1'b1;
        end else begin
            o_rem  = w_shift[DIV_QW-1:0];
            o_qbit = 1'b0;
        end
    end

endmodule : div_step

// File: rtl/main_divider_seq.sv
// -----------------------------------------------------------------------------
// main_divider_seq
// Sequential restoring divider, 16-bit dividend / 8-bit divisor, one quotient
// bit per clock, valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (dividend, divisor sampled on accept)
//   out_valid/out_ready : result handshake (quotient, remainder, flags)
//   div_by_zero         : divisor was zero (quotient saturated, remainder = dividend[7:0])
//   overflow            : true quotient exceeds 8 bits (quotient saturated, remainder 0)
// -----------------------------------------------------------------------------
module main_divider_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int QW = DIV_QW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [QW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [QW-1:0] remainder,
    output logic          div_by_zero,
    output logic          overflow
);

    div_state_e  r_state;
    div_state_e  w_next_state;
    logic [2:0]  r_cnt;
    logic [QW-1:0] r_divisor;
    logic [QW-1:0] r_dvd_lo;     // low dividend byte, shifted left to feed bits MSB first
    logic [QW-1:0] r_rem;
    logic [QW-1:0] r_quot;
    logic          r_dz;
    logic          r_ov;

    logic          w_accept;
    logic          w_is_zero;
    logic          w_is_ovf;
    logic [QW-1:0] w_step_rem;
    logic          w_step_qbit;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_is_zero = (divisor == '0);
    // With a nonzero divisor the quotient fits in 8 bits only if the high
    // dividend byte is strictly below the divisor.
    assign w_is_ovf  = !w_is_zero && (dividend[DW-1:QW] >= divisor);

    div_step u_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .i_bit     (r_dvd_lo[QW-1]),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next_state = (w_is_zero || w_is_ovf) ? DONE : CALC;
            CALC: if (r_cnt == 3'd0) w_next_state = DONE;
            DONE: if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: pure functions of the registered state, so neither
    // handshake output depends combinationally on an input.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 3'd0;
            r_divisor <= '0;
            r_dvd_lo  <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_dz      <= 1'b0;
            r_ov      <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= divisor;
            r_dvd_lo  <= dividend[QW-1:0];
            r_dz      <= w_is_zero;
            r_ov      <= w_is_ovf;
            if (w_is_zero) begin
                r_quot <= DIV_QSAT;
                r_rem  <= dividend[QW-1:0];
            end else if (w_is_ovf) begin
                r_quot <= DIV_QSAT;
                r_rem  <= '0;
            end else begin
                r_quot <= '0;
                r_rem  <= dividend[DW-1:QW];
                r_cnt  <= 3'd7;
            end
        end else if (r_state == CALC) begin
            r_rem    <= w_step_rem;
            r_quot   <= {r_quot[QW-2:0], w_step_qbit};
            r_dvd_lo <= {r_dvd_lo[QW-2:0], 1'b0};
            if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule : main_divider_seq
